// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, MMIO offsets.
// Also holds the alignment rule so the top and any future users agree on it.
package dmem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] OFF_GPIO_OUT = 32'd0;
    localparam logic [31:0] OFF_GPIO_IN  = 32'd4;
    localparam logic [31:0] OFF_CYCLE    = 32'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // MMIO registers are word-only, so any narrow MMIO access is rejected too.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       mmio);
        logic m;
        case (size)
            SIZE_BYTE: m = mmio;
            SIZE_HALF: m = addr_lo[0] | mmio;
            default:   m = (addr_lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_ctrl_byte_lane.sv
// Combinational byte-lane steering: store write mask, store data replication, load extract/extend.
// Little-endian lanes; size 11 behaves as a word.
module dmem_ctrl_byte_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wlanes_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (addr_lo_i)
            2'd0:    rbyte = rword_i[7:0];
            2'd1:    rbyte = rword_i[15:8];
            2'd2:    rbyte = rword_i[23:16];
            default: rbyte = rword_i[31:24];
        endcase
        rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        wmask_o  = 4'b1111;
        wlanes_o = wdata_i;
        rdata_o  = rword_i;
        case (size_i)
            SIZE_BYTE: begin
                wmask_o  = 4'b0001 << addr_lo_i;
                wlanes_o = {4{wdata_i[7:0]}};
                rdata_o  = {{24{sign_ext_i & rbyte[7]}}, rbyte};
            end
            SIZE_HALF: begin
                wmask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wlanes_o = {2{wdata_i[15:0]}};
                rdata_o  = {{16{sign_ext_i & rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latched req/ready handshake with programmable wait states,
// byte/half/word RAM access and a word-only MMIO window (GPIO, free-running cycle counter).
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 6,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        misalign,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        we_q, sext_q, mis_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] gpio_out_q, cycle_q;
    logic [31:0] ram_q [2**ADDR_WIDTH];

    logic                  accept, mis_in, is_mmio, commit;
    logic [31:0]           mmio_off, rword, rext, wlanes;
    logic [3:0]            wmask;
    logic [ADDR_WIDTH-1:0] ram_idx;

    assign accept   = (state_q == S_IDLE) && req;
    assign mis_in   = is_misaligned(size, addr[1:0], addr >= MMIO_BASE);
    assign is_mmio  = addr_q >= MMIO_BASE;
    assign mmio_off = addr_q - MMIO_BASE;
    assign ram_idx  = addr_q[ADDR_WIDTH+1:2];
    assign commit   = (state_q == S_RESP) && we_q && !mis_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wcnt_d  = 4'(WAIT_STATES);
                    state_d = (mis_in || WAIT_STATES == 0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 4'd0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            mis_q      <= 1'b0;
            size_q     <= SIZE_BYTE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            gpio_out_q <= 32'd0;
            cycle_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                we_q    <= we;
                sext_q  <= sign_ext;
                mis_q   <= mis_in;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (commit && is_mmio && mmio_off == OFF_GPIO_OUT) gpio_out_q <= wdata_q;
            // A clearing write takes priority over the free-running increment.
            if (commit && is_mmio && mmio_off == OFF_CYCLE) cycle_q <= 32'd0;
            else                                             cycle_q <= cycle_q + 32'd1;
        end
    end

    // RAM contents survive reset; only the in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (!reset && commit && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) ram_q[ram_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        rword = ram_q[ram_idx];
        if (is_mmio) begin
            case (mmio_off)
                OFF_GPIO_OUT: rword = gpio_out_q;
                OFF_GPIO_IN:  rword = gpio_in;
                OFF_CYCLE:    rword = cycle_q;
                default:      rword = 32'd0;
            endcase
        end
    end

    dmem_ctrl_byte_lane u_lane (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .sign_ext_i (sext_q),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .wmask_o    (wmask),
        .wlanes_o   (wlanes),
        .rdata_o    (rext)
    );

    assign ready    = (state_q == S_RESP);
    assign misalign = ready && mis_q;
    assign rdata    = (ready && !we_q && !mis_q) ? rext : 32'd0;
    assign stall    = req && !ready;
    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with WAIT_STATES=2, ADDR_WIDTH=6.
module tb_dmem_ctrl;

    localparam logic [31:0] MB = 32'hFFFF0000;
    localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10;

    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'd0, wdata = 32'd0, gpio_in = 32'd0;
    logic [31:0] rdata, gpio_out;
    logic        ready, stall, misalign;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        mis;
    int          lat, stl;

    dmem_ctrl #(.ADDR_WIDTH(6), .WAIT_STATES(2), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall),
        .misalign(misalign), .gpio_in(gpio_in), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    // Drives one request starting 1ns after a rising edge; returns 1ns after the edge ending RESP.
    task automatic access(input logic w, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] r, output int l, output logic m, output int s);
        bit done = 0;
        r = 32'd0; l = -1; m = 1'b0; s = 0;
        req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (ready) begin
                r = rdata; m = misalign; l = n; done = 1;
            end else if (stall) begin
                s++;
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL timeout addr=%h: no ready within 40 cycles", a);
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0)      begin n_err++; $display("FAIL reset_ready got %b exp 0", ready); end
        n_cmp++; if (misalign !== 1'b0)   begin n_err++; $display("FAIL reset_misalign got %b exp 0", misalign); end
        n_cmp++; if (rdata !== 32'd0)     begin n_err++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        n_cmp++; if (gpio_out !== 32'd0)  begin n_err++; $display("FAIL reset_gpio got %h exp 0", gpio_out); end
        n_cmp++; if (dut.cycle_q !== 32'd0) begin n_err++; $display("FAIL reset_cycle got %h exp 0", dut.cycle_q); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_word();
        access(1, SW, 0, 32'h10, 32'h12345678, rd, lat, mis, stl);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL sw_latency got %0d exp 3", lat); end
        n_cmp++; if (stl !== 3) begin n_err++; $display("FAIL sw_stall_cycles got %0d exp 3", stl); end
        access(0, SW, 0, 32'h10, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (lat !== 3)            begin n_err++; $display("FAIL lw_latency got %0d exp 3", lat); end
        n_cmp++; if (rd !== 32'h12345678)  begin n_err++; $display("FAIL lw_data got %h exp 12345678", rd); end
        n_cmp++; if (mis !== 1'b0)         begin n_err++; $display("FAIL lw_misalign got %b exp 0", mis); end
    endtask

    task automatic test_narrow();
        access(1, SB, 0, 32'h11, 32'h000000AB, rd, lat, mis, stl);
        access(0, SB, 1, 32'h11, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'hFFFFFFAB) begin n_err++; $display("FAIL lb_sext got %h exp ffffffab", rd); end
        access(0, SB, 0, 32'h11, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'h000000AB) begin n_err++; $display("FAIL lbu got %h exp 000000ab", rd); end
        access(0, SW, 0, 32'h10, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'h1234AB78) begin n_err++; $display("FAIL lw_after_sb got %h exp 1234ab78", rd); end
        access(1, SH, 0, 32'h12, 32'h7777BEEF, rd, lat, mis, stl);
        access(0, SH, 1, 32'h12, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_err++; $display("FAIL lh_sext got %h exp ffffbeef", rd); end
        access(0, SH, 0, 32'h12, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'h0000BEEF) begin n_err++; $display("FAIL lhu got %h exp 0000beef", rd); end
        access(0, SW, 0, 32'h10, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'hBEEFAB78) begin n_err++; $display("FAIL lw_after_sh got %h exp beefab78", rd); end
    endtask

    task automatic test_misalign();
        access(0, SH, 1, 32'h13, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (mis !== 1'b1)    begin n_err++; $display("FAIL lh_mis_flag got %b exp 1", mis); end
        n_cmp++; if (lat !== 1)       begin n_err++; $display("FAIL lh_mis_latency got %0d exp 1", lat); end
        n_cmp++; if (rd !== 32'd0)    begin n_err++; $display("FAIL lh_mis_rdata got %h exp 0", rd); end
        access(1, SW, 0, 32'h12, 32'hFFFFFFFF, rd, lat, mis, stl);
        n_cmp++; if (mis !== 1'b1)    begin n_err++; $display("FAIL sw_mis_flag got %b exp 1", mis); end
        access(0, SW, 0, 32'h10, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'hBEEFAB78) begin n_err++; $display("FAIL lw_after_mis got %h exp beefab78", rd); end
        access(0, SB, 0, MB, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (mis !== 1'b1)    begin n_err++; $display("FAIL mmio_byte_mis got %b exp 1", mis); end
    endtask

    task automatic test_mmio();
        gpio_in = 32'h5A5A0000;
        access(1, SW, 0, MB, 32'hDEADBEEF, rd, lat, mis, stl);
        n_cmp++; if (gpio_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL gpio_out got %h exp deadbeef", gpio_out); end
        access(0, SW, 0, MB, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL gpio_out_rd got %h exp deadbeef", rd); end
        access(1, SW, 0, MB + 32'd4, 32'h11111111, rd, lat, mis, stl);
        access(0, SW, 0, MB + 32'd4, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'h5A5A0000) begin n_err++; $display("FAIL gpio_in_rd got %h exp 5a5a0000", rd); end
        access(0, SW, 0, MB + 32'd12, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL mmio_hole got %h exp 0", rd); end
    endtask

    task automatic test_counter();
        access(1, SW, 0, MB + 32'd8, 32'h0, rd, lat, mis, stl);
        repeat (10) @(posedge clk);
        #1;
        access(0, SW, 0, MB + 32'd8, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'd13) begin n_err++; $display("FAIL cycle_after_clear got %0d exp 13", rd); end
        force dut.cycle_q = 32'hFFFFFFFF;
        #1;
        release dut.cycle_q;
        @(posedge clk); #1;
        n_cmp++; if (dut.cycle_q !== 32'd0) begin n_err++; $display("FAIL cycle_wrap got %h exp 0", dut.cycle_q); end
        access(0, SW, 0, MB + 32'd8, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'd3) begin n_err++; $display("FAIL cycle_post_wrap got %0d exp 3", rd); end
    endtask

    task automatic test_reset_busy();
        access(1, SW, 0, 32'h20, 32'h11112222, rd, lat, mis, stl);
        req = 1'b1; we = 1'b1; size = SW; addr = 32'h20; wdata = 32'h99999999;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_busy_ready got %b exp 0", ready); end
        @(posedge clk); #1;
        reset = 1'b0; req = 1'b0; we = 1'b0;
        n_cmp++; if (gpio_out !== 32'd0) begin n_err++; $display("FAIL rst_busy_gpio got %h exp 0", gpio_out); end
        access(0, SW, 0, 32'h20, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'h11112222) begin n_err++; $display("FAIL rst_busy_nowrite got %h exp 11112222", rd); end
    endtask

    task automatic test_alias();
        access(1, SW, 0, 32'h100, 32'h0BADCAFE, rd, lat, mis, stl);
        access(0, SW, 0, 32'h0, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'h0BADCAFE) begin n_err++; $display("FAIL alias_word0 got %h exp 0badcafe", rd); end
        access(0, SW, 0, 32'h10, 32'h0, rd, lat, mis, stl);
        n_cmp++; if (rd !== 32'hBEEFAB78) begin n_err++; $display("FAIL alias_other got %h exp beefab78", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_narrow();
        test_misalign();
        test_mmio();
        test_counter();
        test_reset_busy();
        test_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
